nibble_serial_adder: RTL

Sequential WIDTH-bit adder that reuses one 4-bit ripple adder, processing one nibble per clock, LSB nibble first. Operands enter through a valid/ready handshake. The block holds the carry between nibbles and returns the registered result through a second valid/ready handshake. It sits between operand producers and any consumer that can trade latency for area, and it replaces a full-width adder.

---
 rtl/nibble_adder_pkg.sv | 17 +
 rtl/fulladder4.sv | 27 ++
 rtl/nibble_serial_adder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder: FSM states, nibble
// width and the nibble-count helper.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/fulladder4.sv
// 4-bit ripple-carry adder. This is the only arithmetic element in the
// serial datapath.
module fulladder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       c_o
);

  logic [4:0] carry;

  // NOTE: every signal written in always_comb is assigned on every path
  // before it is read, so no latch can be inferred.
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = c_i;
    for (int i = 0; i < 4; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that processes one nibble per clock, LSB first, through a
// shared fulladder4. Define NIBBLE_ADDER_SUB_EN to add the sub_i port and
// enable subtraction.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
`ifdef NIBBLE_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  import nibble_adder_pkg::*;

  localparam int N     = nibble_count(WIDTH);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(N - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh, sum_next;
  logic [WIDTH-1:0]   b_load;
  logic               carry_q, cin_load;
  logic               a_msb_q, b_msb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NIBBLE_W-1:0] nib_sum;
  logic               nib_cout;
  logic               sub;
  logic               accept, last_nib;

`ifdef NIBBLE_ADDER_SUB_EN
  assign sub = sub_i;
`else
  assign sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so only the B load and the initial carry change.
  assign b_load   = sub ? ~b_i : b_i;
  assign cin_load = sub ? 1'b1 : carry_i;

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign accept   = valid_i && ready_o;
  assign last_nib = (cnt_q == LAST_NIB);

  fulladder4 u_adder (
    .a_i   (a_sh[NIBBLE_W-1:0]),
    .b_i   (b_sh[NIBBLE_W-1:0]),
    .c_i   (carry_q),
    .sum_o (nib_sum),
    .c_o   (nib_cout)
  );

  // The new nibble enters at the top, so after N shifts the word is in place.
  assign sum_next = (sum_sh >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (ready_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry_q    <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      cnt_q      <= '0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (accept) begin
      a_sh    <= a_i;
      b_sh    <= b_load;
      carry_q <= cin_load;
      a_msb_q <= a_i[WIDTH-1];
      b_msb_q <= b_load[WIDTH-1];
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> NIBBLE_W;
      b_sh    <= b_sh >> NIBBLE_W;
      sum_sh  <= sum_next;
      carry_q <= nib_cout;
      cnt_q   <= cnt_q + 1'b1;
      if (last_nib) begin
        sum_o      <= sum_next;
        carry_o    <= nib_cout;
        overflow_o <= (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
      end
    end
  end

endmodule
